wb_bus_ctrl: RTL

WB_BUS_CTRL -- requirements
Module: wb_bus_ctrl

---
 rtl/soc_map_pkg.sv | 36 +++
 rtl/wb_addr_decode.sv | 22 ++
 rtl/wb_bus_ctrl.sv | 109 ++++++++++
 3 files changed

// File: rtl/soc_map_pkg.sv
// Shared SoC address map, slave indices, controller state encoding and
// the slave read-data selection helper for the Wishbone bus controller.
package soc_map_pkg;

   localparam int unsigned TIMEOUT_DEFAULT = 255;

   localparam int NUM_SLAVES  = 3;
   localparam int SLV_BOOTROM = 0;
   localparam int SLV_RAM     = 1;
   localparam int SLV_IO      = 2;

   localparam logic [31:0] BOOTROM_BASE = 32'hB000_0000;
   localparam logic [31:0] BOOTROM_MASK = 32'hFFFF_8000;
   localparam logic [31:0] RAM_BASE     = 32'hB000_8000;
   localparam logic [31:0] RAM_MASK     = 32'hFFFF_8000;
   localparam logic [31:0] IO_BASE      = 32'hC000_0000;
   localparam logic [31:0] IO_MASK      = 32'hFFFF_0000;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_ERR  = 2'd2
   } state_e;

   // AND-OR mux over the packed slave data bus; sel is one-hot or zero.
   function automatic logic [31:0] slave_word(input logic [32*NUM_SLAVES-1:0] bus,
                                              input logic [NUM_SLAVES-1:0]    sel);
      logic [31:0] w;
      w = '0;
      for (int n = 0; n < NUM_SLAVES; n++) begin
         if (sel[n]) w = w | bus[32*n +: 32];
      end
      return w;
   endfunction

endpackage

// File: rtl/wb_addr_decode.sv
// Combinational address decoder: one-hot slave select plus a mapped flag.
// Writes into the bootrom window are reported as unmapped.
module wb_addr_decode
   import soc_map_pkg::*;
(
   input  logic [31:0]           addr,
   input  logic                  we,
   output logic [NUM_SLAVES-1:0] sel,
   output logic                  mapped
);

   // NOTE: every output of a combinational block gets a default first, so no
   // path through the block can leave it unassigned and infer a latch.
   always_comb begin
      sel              = '0;
      sel[SLV_BOOTROM] = ((addr & BOOTROM_MASK) == BOOTROM_BASE) && !we;
      sel[SLV_RAM]     = ((addr & RAM_MASK) == RAM_BASE);
      sel[SLV_IO]      = ((addr & IO_MASK) == IO_BASE);
      mapped           = |sel;
   end

endmodule

// File: rtl/wb_bus_ctrl.sv
// Single-master Wishbone interconnect: decodes the CPU request to one of three
// slaves, keeps one transaction in flight and reports unmapped or timed-out cycles.
module wb_bus_ctrl
   import soc_map_pkg::*;
#(
   parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    i_wb_cyc,
   input  logic                    i_wb_stb,
   input  logic                    i_wb_we,
   input  logic [31:0]             i_wb_addr,
   input  logic [31:0]             i_wb_data,
   output logic [31:0]             o_wb_data,
   output logic                    o_wb_stall,
   output logic                    o_wb_ack,
   output logic                    o_wb_err,
   output logic [NUM_SLAVES-1:0]   o_s_stb,
   output logic                    o_s_we,
   output logic [15:0]             o_s_addr,
   output logic [31:0]             o_s_data,
   input  logic [32*NUM_SLAVES-1:0] i_s_data,
   input  logic [NUM_SLAVES-1:0]   i_s_stall,
   input  logic [NUM_SLAVES-1:0]   i_s_ack
);

   localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

   state_e                  state_q;
   logic [NUM_SLAVES-1:0]   sel_q;
   logic [CNT_W-1:0]        cnt_q;

   logic [NUM_SLAVES-1:0]   dec_sel;
   logic                    dec_mapped;
   logic                    req;
   logic                    req_stalled;
   logic                    busy_ack;
   logic                    timeout_hit;

   wb_addr_decode u_decode (
      .addr   (i_wb_addr),
      .we     (i_wb_we),
      .sel    (dec_sel),
      .mapped (dec_mapped)
   );

   assign req         = i_wb_cyc & i_wb_stb;
   assign req_stalled = |(i_s_stall & dec_sel);

   // Both completions require the master to still own the cycle; a dropped
   // cyc aborts silently and wins over a coincident ack or timeout.
   assign busy_ack    = (state_q == ST_BUSY) && i_wb_cyc && |(i_s_ack & sel_q);
   assign timeout_hit = (state_q == ST_BUSY) && i_wb_cyc && (cnt_q == CNT_W'(TIMEOUT - 1));

   assign o_s_we   = i_wb_we;
   assign o_s_addr = i_wb_addr[15:0];
   assign o_s_data = i_wb_data;

   always_comb begin
      o_s_stb    = '0;
      o_wb_stall = 1'b1;
      case (state_q)
         ST_IDLE: begin
            o_s_stb    = req ? dec_sel : '0;
            o_wb_stall = req & req_stalled;
         end
         default: o_wb_stall = 1'b1;
      endcase
      o_wb_ack  = busy_ack;
      o_wb_err  = (state_q == ST_ERR) || (timeout_hit && !busy_ack);
      o_wb_data = busy_ack ? slave_word(i_s_data, sel_q) : '0;
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         sel_q   <= '0;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               cnt_q <= '0;
               if (req) begin
                  if (!dec_mapped) begin
                     state_q <= ST_ERR;
                  end else if (!req_stalled) begin
                     sel_q   <= dec_sel;
                     state_q <= ST_BUSY;
                  end
               end
            end
            ST_BUSY: begin
               if (!i_wb_cyc || busy_ack || timeout_hit) begin
                  state_q <= ST_IDLE;
                  sel_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            ST_ERR:  state_q <= ST_IDLE;
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule
